uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO (8-bit write side, 12-bit write-count) between NUM_REQ independent message sources, e.g. push-button status, direction, drive state and terminal control.
- Round-robin arbitration at message granularity: a granted source keeps the FIFO until its last byte, so messages never interleave.
- A grant is issued only when the FIFO has room for a worst-case message.
- Sits between the message generators and the FIFO write port, replacing per-source direct writes.

Parameters:
- NUM_REQ, 4, number of requesting sources.
- FIFO_DEPTH, 4095, usable FIFO entries.
- MAX_MSG_LEN, 64, maximum bytes per message; also the free-space threshold for granting.
- TIMEOUT, 1023, stall cycles tolerated mid-message before the grant is revoked.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-source request; the source holds it high while a byte is presented.
- reqData  in  NUM_REQ*8  per-source byte; source i uses bits [8i+7:8i].
- reqLast  in  NUM_REQ  marks the presented byte as the final byte of the message.
- ack  out  NUM_REQ  combinational; byte from source i accepted on this clock edge.
- grant  out  NUM_REQ  registered one-hot owner of the FIFO; all-zero when idle.
- fifoFull  in  1  FIFO full flag.
- wrDataCount  in  12  FIFO write-side occupancy.
- din  out  8  FIFO write data, registered.
- writeEn  out  1  FIFO write enable, registered.
- busy  out  1  high while in XFER.
- timeoutErr  out  1  sticky; source stalled mid-message for more than TIMEOUT cycles.
- overrunErr  out  1  sticky; message exceeded MAX_MSG_LEN bytes.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; grant = 0; din = 0; writeEn = 0.
  - rrPtr = 0; byteCnt = 0; stallCnt = 0.
  - timeoutErr = 0; overrunErr = 0.
- Reset mid-message: the partial message stays in the FIFO. No cleanup is performed.
- Eligibility test: spaceOk = (wrDataCount + MAX_MSG_LEN <= FIFO_DEPTH), evaluated at 13-bit width with no wrap.
- IDLE state:
  - writeEn = 0.
  - If spaceOk and any req is high, select the first requester at or after rrPtr (circular search). Set grant to that one-hot value, byteCnt = 0, stallCnt = 0, state = XFER.
  - Grant appears 1 cycle after req. No byte is taken in IDLE; ack = 0.
- XFER state, with g = granted index:
  - ack[g] = req[g] & ~fifoFull. All other ack bits are 0.
  - On an ack edge:
    - din <= reqData[g]; writeEn <= 1; byteCnt += 1; stallCnt = 0.
    - If reqLast[g]: grant <= 0, rrPtr <= (g+1) mod NUM_REQ, state <= IDLE.
    - Otherwise, if byteCnt+1 == MAX_MSG_LEN: overrunErr <= 1, and release exactly as for a last byte.
  - No ack: writeEn <= 0; stallCnt += 1.
    - fifoFull stalls count the same as a missing req.
    - When stallCnt reaches TIMEOUT: timeoutErr <= 1, grant <= 0, rrPtr <= g+1, state <= IDLE.
- Throughput: one byte per clock while req is high and the FIFO is not full. The FIFO sees each byte 1 cycle after its ack.
- Minimum gap between messages: 1 idle cycle, which is the IDLE arbitration cycle.
- Simultaneous requests: the round-robin order guarantees no source waits more than NUM_REQ-1 messages.
- Requests arriving during XFER wait. Deasserting req in IDLE withdraws the request without penalty.
- Error flags are cleared only by reset.

Test Plan:
- Single source: src1 sends "Dir: Stop" plus CR and LF (11 bytes), last on LF, wrDataCount = 0.
  - Grant goes 0010 one cycle after req.
  - 11 consecutive writeEn pulses with din matching the string.
  - Grant returns to 0000, then the block is back in IDLE.
- All four sources request simultaneously with 3-byte messages, starting from rrPtr = 0.
  - Grant order 0001, 0010, 0100, 1000.
  - No interleaving; 12 writes total.
  - Next round starts at src0.
- FIFO space gate: wrDataCount = 4032 with src0 requesting.
  - No grant (4032+64 > 4095).
  - Drop wrDataCount to 4031: grant is asserted the next cycle.
- Backpressure: fifoFull asserted for 5 cycles at byte 3 of a 10-byte message.
  - ack and writeEn are 0 for those 5 cycles.
  - The message completes intact with exactly 10 writes.
- Timeout: granted src2 drops req after 2 bytes.
  - After 1023 stall cycles: timeoutErr = 1, grant = 0.
  - src3, which was pending, is granted next.
- Overrun: src0 sends 70 bytes with no last.
  - Exactly 64 writes.
  - overrunErr = 1, grant released, rrPtr = 1.
  - Assert rst low mid-transfer: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one UART TX FIFO write port
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FIFO_DEPTH  = 4095,
    parameter int MAX_MSG_LEN = 64,
    parameter int TIMEOUT     = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] reqData,
    input  logic [NUM_REQ-1:0]   reqLast,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 fifoFull,
    input  logic [11:0]          wrDataCount,
    output logic [7:0]           din,
    output logic                 writeEn,
    output logic                 busy,
    output logic                 timeoutErr,
    output logic                 overrunErr
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_MSG_LEN + 1);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, XFER} stateT;

    stateT         state;
    logic [IW-1:0] rrPtr, gIdx, pickIdx, nextPtr;
    logic [BW-1:0] byteCnt, byteInc;
    logic [SW-1:0] stallCnt;
    logic          pickAny, spaceOk, accepted, endMsg, stallOut;

    assign spaceOk  = ({1'b0, wrDataCount} + 13'(MAX_MSG_LEN)) <= 13'(FIFO_DEPTH);
    assign ack      = (state == XFER && !fifoFull) ? (grant & req) : '0;
    assign accepted = |ack;
    assign byteInc  = byteCnt + 1'b1;
    assign endMsg   = reqLast[gIdx] || byteInc == BW'(MAX_MSG_LEN);
    assign stallOut = stallCnt == SW'(TIMEOUT - 1);
    assign nextPtr  = (gIdx == IW'(NUM_REQ - 1)) ? '0 : gIdx + IW'(1);
    assign busy     = state == XFER;

    // circular search from rrPtr; lower offsets are visited last so they win
    always_comb begin
        pickIdx = '0;
        pickAny = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(rrPtr) + i) % NUM_REQ]) begin
                pickIdx = IW'((int'(rrPtr) + i) % NUM_REQ);
                pickAny = 1'b1;
            end
        end
    end

    // arbitration FSM with registered FIFO write port and sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            gIdx       <= '0;
            rrPtr      <= '0;
            byteCnt    <= '0;
            stallCnt   <= '0;
            din        <= '0;
            writeEn    <= 1'b0;
            timeoutErr <= 1'b0;
            overrunErr <= 1'b0;
        end else if (state == IDLE) begin
            writeEn <= 1'b0;
            if (spaceOk && pickAny) begin
                grant    <= NUM_REQ'(1) << pickIdx;
                gIdx     <= pickIdx;
                byteCnt  <= '0;
                stallCnt <= '0;
                state    <= XFER;
            end
        end else if (accepted) begin
            din      <= reqData[8*gIdx +: 8];
            writeEn  <= 1'b1;
            byteCnt  <= byteInc;
            stallCnt <= '0;
            if (endMsg) begin
                overrunErr <= overrunErr | ~reqLast[gIdx];
                grant      <= '0;
                rrPtr      <= nextPtr;
                state      <= IDLE;
            end
        end else begin
            writeEn  <= 1'b0;
            stallCnt <= stallCnt + 1'b1;
            if (stallOut) begin
                timeoutErr <= 1'b1;
                grant      <= '0;
                rrPtr      <= nextPtr;
                state      <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a write-side scoreboard for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic [3:0]  req = '0, reqLast = '0;
    logic [31:0] reqData = '0;
    logic [3:0]  ack, grant;
    logic        fifoFull = 1'b0;
    logic [11:0] wrDataCount = '0;
    logic [7:0]  din;
    logic        writeEn, busy, timeoutErr, overrunErr;

    int         total = 0, bad = 0, wrCount = 0;
    logic [7:0] expQ[$];
    logic [3:0] grantLog[$];
    logic [3:0] prevGrant = '0;
    bit         sbOn = 1'b1;
    logic [8:0] srcMem[4][0:255];
    int         rdPtr[4], wrPtr[4];
    bit   [3:0] en = '1;
    logic [3:0] ackN = '0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .reqData(reqData), .reqLast(reqLast),
        .ack(ack), .grant(grant), .fifoFull(fifoFull), .wrDataCount(wrDataCount),
        .din(din), .writeEn(writeEn), .busy(busy), .timeoutErr(timeoutErr),
        .overrunErr(overrunErr)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic enq(input int s, input logic [7:0] d, input bit last, input bit sb);
        srcMem[s][wrPtr[s] % 256] = {last, d};
        wrPtr[s]++;
        if (sb) expQ.push_back(d);
    endtask

    task automatic waitIdle(input string name, input int lim);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(n < lim), 1);
    endtask

    task automatic pulseReset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // source models: present queue head, pop on the edge that acked it
    initial forever begin
        @(negedge clk);
        ackN = ack;
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            if (ackN[i]) rdPtr[i]++;
            if (!en[i]) rdPtr[i] = wrPtr[i];
            req[i] = rdPtr[i] != wrPtr[i];
            {reqLast[i], reqData[8*i +: 8]} = srcMem[i][rdPtr[i] % 256];
        end
    end

    // monitor: every FIFO write is popped against the expected byte stream
    initial begin : mon
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (writeEn) begin
                wrCount++;
                if (sbOn) begin
                    total++;
                    if (expQ.size() == 0) begin
                        bad++;
                        $display("FAIL sb_extra: got din=0x%02h expected no write", din);
                    end else begin
                        e = expQ.pop_front();
                        if (din !== e) begin
                            bad++;
                            $display("FAIL sb_din: got 0x%02h expected 0x%02h", din, e);
                        end
                    end
                end
            end
            if (grant != prevGrant && grant != 0) grantLog.push_back(grant);
            prevGrant = grant;
        end
    end

    initial begin
        string s;
        int base, n, cnt;
        s = "Dir: Stop\r\n";
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_writeEn", int'(writeEn), 0);
        chk("rst_din", int'(din), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeoutErr", int'(timeoutErr), 0);
        chk("rst_overrunErr", int'(overrunErr), 0);
        @(posedge clk); #1 rst = 1'b1;

        // single source string
        @(posedge clk); #1;
        for (int i = 0; i < s.len(); i++) enq(1, s[i], i == s.len() - 1, 1);
        base = wrCount;
        @(negedge clk); chk("t1_grant_pre", int'(grant), 0);
        @(negedge clk); chk("t1_grant", int'(grant), 2);
        waitIdle("t1_done", 50);
        chk("t1_writes", wrCount - base, 11);
        chk("t1_grant_end", int'(grant), 0);
        chk("t1_busy_end", int'(busy), 0);

        // four simultaneous requesters from rrPtr = 0
        pulseReset();
        grantLog.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) enq(i, 8'(16 * i + k + 1), k == 2, 1);
        base = wrCount;
        waitIdle("t2_done", 100);
        chk("t2_writes", wrCount - base, 12);
        for (int i = 0; i < 4; i++)
            chk("t2_order", i < grantLog.size() ? int'(grantLog[i]) : 0, 1 << i);
        grantLog.delete();
        @(posedge clk); #1;
        enq(0, 8'hA0, 1, 1);
        enq(1, 8'hA1, 1, 1);
        waitIdle("t2b_done", 50);
        chk("t2b_first", grantLog.size() > 0 ? int'(grantLog[0]) : 0, 1);
        chk("t2b_second", grantLog.size() > 1 ? int'(grantLog[1]) : 0, 2);

        // FIFO space gate
        @(posedge clk); #1;
        wrDataCount = 12'd4032;
        enq(0, 8'h55, 1, 1);
        repeat (6) @(negedge clk);
        chk("t3_no_grant", int'(grant), 0);
        chk("t3_not_busy", int'(busy), 0);
        @(posedge clk); #1 wrDataCount = 12'd4031;
        @(negedge clk); chk("t3_grant_pre", int'(grant), 0);
        @(negedge clk); chk("t3_grant", int'(grant), 1);
        waitIdle("t3_done", 50);
        wrDataCount = '0;

        // backpressure mid-message
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) enq(0, 8'hB0 + 8'(k), k == 9, 1);
        base = wrCount;
        n = 0;
        while (wrCount < base + 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 fifoFull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_ack_stall", int'(ack), 0);
            if (k > 0) chk("t4_wr_stall", int'(writeEn), 0);
            @(posedge clk);
        end
        #1 fifoFull = 1'b0;
        @(negedge clk); chk("t4_wr_stall_last", int'(writeEn), 0);
        waitIdle("t4_done", 50);
        chk("t4_writes", wrCount - base, 10);

        // timeout: src2 stalls after 2 bytes, src3 pending
        grantLog.delete();
        @(posedge clk); #1;
        enq(2, 8'hC0, 0, 1);
        enq(2, 8'hC1, 0, 1);
        enq(3, 8'hD0, 1, 1);
        cnt = 0;
        n = 0;
        while (!timeoutErr && n < 1300) begin
            @(negedge clk);
            n++;
            if (grant == 4'b0100) cnt++;
        end
        chk("t5_grant_cycles", cnt, 1025);
        chk("t5_timeoutErr", int'(timeoutErr), 1);
        chk("t5_grant_rel", int'(grant), 0);
        waitIdle("t5_done", 50);
        chk("t5_first", grantLog.size() > 0 ? int'(grantLog[0]) : 0, 4);
        chk("t5_next", grantLog.size() > 1 ? int'(grantLog[1]) : 0, 8);

        // overrun: 70 bytes, no last
        @(posedge clk); #1;
        for (int k = 0; k < 70; k++) enq(0, 8'(k + 1), 0, k < 64);
        base = wrCount;
        n = 0;
        while (grant != 4'b0001 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 wrDataCount = 12'd4095;
        n = 0;
        while (!overrunErr && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_overrunErr", int'(overrunErr), 1);
        chk("t6_grant_rel", int'(grant), 0);
        repeat (3) @(negedge clk);
        chk("t6_no_regrant", int'(grant), 0);
        chk("t6_writes", wrCount - base, 64);
        en[0] = 1'b0;
        grantLog.delete();
        repeat (2) @(posedge clk);
        #1;
        en[0] = 1'b1;
        wrDataCount = '0;
        enq(1, 8'hE1, 1, 1);
        enq(0, 8'hE0, 1, 1);
        waitIdle("t6_done", 50);
        chk("t6_rr_first", grantLog.size() > 0 ? int'(grantLog[0]) : 0, 2);
        chk("t6_rr_second", grantLog.size() > 1 ? int'(grantLog[1]) : 0, 1);

        // asynchronous reset mid-transfer
        chk("sb_leftover", expQ.size(), 0);
        sbOn = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) enq(2, 8'h70 + 8'(k), k == 19, 0);
        base = wrCount;
        n = 0;
        while (wrCount < base + 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b0;
        #1;
        chk("t7_grant", int'(grant), 0);
        chk("t7_ack", int'(ack), 0);
        chk("t7_writeEn", int'(writeEn), 0);
        chk("t7_din", int'(din), 0);
        chk("t7_busy", int'(busy), 0);
        chk("t7_timeoutErr", int'(timeoutErr), 0);
        chk("t7_overrunErr", int'(overrunErr), 0);
        en[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); chk("t7_idle_after", int'(grant), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
